// File: rtl/add16u_eval_pkg.sv
// Shared types and helpers for the 16-bit approximate-adder error monitors.
// Holds the run-control states, accumulator widths, stage-1 payload and saturating add.
package add16u_eval_pkg;

    localparam int W     = 16;
    localparam int CNT_W = 32;
    localparam int SUM_W = 48;
    localparam int SQ_W  = 80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic         valid;
        logic [W:0]   abs_err;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } s1_t;

    // Adds inc to acc and clamps the result to the all-ones value of a width-bit field.
    function automatic logic [SQ_W-1:0] sat_add(
        input logic [SQ_W-1:0] acc,
        input logic [SQ_W-1:0] inc,
        input int unsigned     width
    );
        logic [SQ_W:0] sum;
        logic [SQ_W:0] limit;
        sum   = {1'b0, acc} + {1'b0, inc};
        limit = ((SQ_W+1)'(1) << width) - (SQ_W+1)'(1);
        return (sum > limit) ? limit[SQ_W-1:0] : sum[SQ_W-1:0];
    endfunction

endpackage

// File: rtl/add16u_err_calc.sv
// Combinational exact-sum and absolute-error calculation for one operand/result triple.
// Width is a parameter so the same block serves monitors for other adder widths.
module add16u_err_calc
    import add16u_eval_pkg::*;
#(
    parameter int CW = W
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic [CW:0]   approx,
    output logic [CW:0]   abs_err
);

    logic [CW:0]          exact;
    logic signed [CW+1:0] diff;

    assign exact = {1'b0, a} + {1'b0, b};
    assign diff  = $signed({1'b0, exact}) - $signed({1'b0, approx});

    // The largest magnitude, 2^(CW+1)-1, still fits in CW+1 bits after negation.
    assign abs_err = diff[CW+1] ? (CW+1)'(-diff) : diff[CW:0];

endmodule

// File: rtl/add16u_err_monitor.sv
// Error-statistics monitor for a 16-bit approximate adder: two-stage pipeline that
// accumulates MAE/WCE/MSE/EP numerators over a programmed run of samples.
module add16u_err_monitor
    import add16u_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] run_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [SQ_W-1:0]  sum_sq_err,
    output logic [W:0]       max_abs_err,
    output logic [W-1:0]     wc_a,
    output logic [W-1:0]     wc_b,
    output state_t           dbg_state
);

    // Handshake: a triple transfers on a rising edge where in_valid and in_ready are both
    // high. in_ready depends only on registered state, never on in_valid; a source holds
    // its triple stable until it transfers.

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] acc_cnt;
    s1_t              s1_q;
    logic [W:0]       abs_err;
    logic [2*W+1:0]   sq;
    logic             xfer;
    logic             start_ok;

    add16u_err_calc #(.CW(W)) u_calc (
        .a       (in_a),
        .b       (in_b),
        .approx  (in_approx),
        .abs_err (abs_err)
    );

    assign in_ready  = (state_q == RUN) && (acc_cnt < len_q);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;
    assign sq        = (2*W+2)'(s1_q.abs_err) * (2*W+2)'(s1_q.abs_err);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (run_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (xfer && (acc_cnt == len_q - CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            // Stage 2 retires on the same edge stage 1 empties, so an empty stage 1
            // means the last update has already landed in the statistics.
            DRAIN: begin
                if (!s1_q.valid) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            acc_cnt     <= '0;
            s1_q        <= '0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_abs_err <= '0;
            wc_a        <= '0;
            wc_b        <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                len_q       <= run_len;
                acc_cnt     <= '0;
                s1_q        <= '0;
                sample_cnt  <= '0;
                err_cnt     <= '0;
                sum_abs_err <= '0;
                sum_sq_err  <= '0;
                max_abs_err <= '0;
                wc_a        <= '0;
                wc_b        <= '0;
            end else begin
                if (xfer) begin
                    acc_cnt      <= acc_cnt + CNT_W'(1);
                    s1_q.valid   <= 1'b1;
                    s1_q.abs_err <= abs_err;
                    s1_q.a       <= in_a;
                    s1_q.b       <= in_b;
                end else begin
                    s1_q.valid <= 1'b0;
                end
                if (s1_q.valid) begin
                    sample_cnt  <= sample_cnt + CNT_W'(1);
                    err_cnt     <= err_cnt + CNT_W'(s1_q.abs_err != '0);
                    sum_abs_err <= SUM_W'(sat_add(SQ_W'(sum_abs_err), SQ_W'(s1_q.abs_err), SUM_W));
                    sum_sq_err  <= sat_add(sum_sq_err, SQ_W'(sq), SQ_W);
                    // Strictly greater: on a tie the earlier sample stays the worst case.
                    if (s1_q.abs_err > max_abs_err) begin
                        max_abs_err <= s1_q.abs_err;
                        wc_a        <= s1_q.a;
                        wc_b        <= s1_q.b;
                    end
                end
            end
        end
    end

endmodule
